// File: rtl/copperv_pkg.sv
// -----------------------------------------------------------------------------
// copperv_pkg
// Shared types and constants for the copperv bus arbiter.
//   arb_state_e      : arbiter FSM states (idle / request / response)
//   arb_grant_e      : which CPU channel currently owns the shared port
//   bus_data_width   : default address/data width of the CPU bus
//   bus_strobe_width : byte-enable width for bus_data_width
//   next_in_ring()   : cyclic successor dw -> dr -> ir -> dw, used by the
//                      round-robin picker
// -----------------------------------------------------------------------------
package copperv_pkg;

  localparam int bus_data_width   = 32;
  localparam int bus_strobe_width = bus_data_width / 8;

  typedef enum logic [1:0] {
    arb_idle,
    arb_req,
    arb_resp
  } arb_state_e;

  typedef enum logic [1:0] {
    grant_none,
    grant_inst,
    grant_data_read,
    grant_data_write
  } arb_grant_e;

  function automatic arb_grant_e next_in_ring(input arb_grant_e g);
    case (g)
      grant_data_write: return grant_data_read;
      grant_data_read:  return grant_inst;
      default:          return grant_data_write;
    endcase
  endfunction

endpackage

// File: rtl/copperv_arb_picker.sv
// -----------------------------------------------------------------------------
// copperv_arb_picker
// Combinational grant select among the three CPU bus requesters.
// Build option: COPPERV_ARB_RR_EN
//   undefined : fixed priority, data write > data read > instruction read.
//   defined   : round robin; a pointer names the requester searched first and
//               moves to the one after the winner on every accepted request.
// Ports:
//   clk, rst  : clock / async active-high reset (round-robin build only)
//   advance   : a request was accepted this cycle (round-robin build only)
//   ir_valid, dr_valid, dw_valid : requester valids
//   grant     : chosen requester, grant_none when nobody requests
// -----------------------------------------------------------------------------
module copperv_arb_picker
  import copperv_pkg::*;
(
`ifdef COPPERV_ARB_RR_EN
  input  logic       clk,
  input  logic       rst,
  input  logic       advance,
`endif
  input  logic       ir_valid,
  input  logic       dr_valid,
  input  logic       dw_valid,
  output arb_grant_e grant
);

`ifdef COPPERV_ARB_RR_EN
  arb_grant_e ptr_q, ptr_d;
  arb_grant_e cand;
  logic       hit;

  always_comb begin
    ptr_d = ptr_q;
    if (advance) ptr_d = next_in_ring(grant);
  end

  // The pointer starts on data write so a fresh reset behaves like the
  // fixed-priority build for the first round.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= grant_data_write;
    else     ptr_q <= ptr_d;
  end

  // Walk the ring from the pointer; first requester with valid high wins.
  always_comb begin
    grant = grant_none;
    cand  = ptr_q;
    hit   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      case (cand)
        grant_data_write: hit = dw_valid;
        grant_data_read:  hit = dr_valid;
        grant_inst:       hit = ir_valid;
        default:          hit = 1'b0;
      endcase
      if (grant == grant_none && hit) grant = cand;
      cand = next_in_ring(cand);
    end
  end
`else
  always_comb begin
    grant = grant_none;
    if      (dw_valid) grant = grant_data_write;
    else if (dr_valid) grant = grant_data_read;
    else if (ir_valid) grant = grant_inst;
  end
`endif

endmodule

// File: rtl/copperv_mem_arbiter.sv
// -----------------------------------------------------------------------------
// copperv_mem_arbiter
// Shares one memory bus port between the copperv instruction-read, data-read
// and data-write channels, one transaction outstanding at a time.
// Build option: COPPERV_ARB_RR_EN selects round-robin instead of fixed
// priority (see copperv_arb_picker).
// Ports:
//   clk, rst                      : clock, async active-high reset
//   ir_addr_* / ir_data_*         : instruction read request / data
//   dr_addr_* / dr_data_*         : data read request / data
//   dw_* / dw_resp_*              : data write request / response
//   m_req_*                       : shared request channel (registered)
//   m_resp_*                      : shared response channel
// Flow: idle (grant, register payload) -> req (m_req_valid until accepted)
//       -> resp (route response to the granted requester) -> idle.
// -----------------------------------------------------------------------------
module copperv_mem_arbiter
  import copperv_pkg::*;
#(
  parameter int bus_width      = bus_data_width,
  parameter int bus_resp_width = 1,
  parameter int strobe_width   = bus_width / 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ir_addr_valid,
  output logic                      ir_addr_ready,
  input  logic [bus_width-1:0]      ir_addr,
  output logic                      ir_data_valid,
  input  logic                      ir_data_ready,
  output logic [bus_width-1:0]      ir_data,
  input  logic                      dr_addr_valid,
  output logic                      dr_addr_ready,
  input  logic [bus_width-1:0]      dr_addr,
  output logic                      dr_data_valid,
  input  logic                      dr_data_ready,
  output logic [bus_width-1:0]      dr_data,
  input  logic                      dw_valid,
  output logic                      dw_ready,
  input  logic [bus_width-1:0]      dw_addr,
  input  logic [bus_width-1:0]      dw_data,
  input  logic [strobe_width-1:0]   dw_strobe,
  output logic                      dw_resp_valid,
  input  logic                      dw_resp_ready,
  output logic [bus_resp_width-1:0] dw_resp,
  output logic                      m_req_valid,
  input  logic                      m_req_ready,
  output logic                      m_req_write,
  output logic [bus_width-1:0]      m_req_addr,
  output logic [bus_width-1:0]      m_req_data,
  output logic [strobe_width-1:0]   m_req_strobe,
  input  logic                      m_resp_valid,
  output logic                      m_resp_ready,
  input  logic [bus_width-1:0]      m_resp_data,
  input  logic [bus_resp_width-1:0] m_resp
);

  arb_state_e                state_q, state_d;
  arb_grant_e                grant_q, grant_d;
  arb_grant_e                pick;
  logic                      req_hs;
  logic                      m_req_write_q, m_req_write_d;
  logic [bus_width-1:0]      m_req_addr_q, m_req_addr_d;
  logic [bus_width-1:0]      m_req_data_q, m_req_data_d;
  logic [strobe_width-1:0]   m_req_strobe_q, m_req_strobe_d;

  copperv_arb_picker u_picker (
`ifdef COPPERV_ARB_RR_EN
    .clk      (clk),
    .rst      (rst),
    .advance  (req_hs),
`endif
    .ir_valid (ir_addr_valid),
    .dr_valid (dr_addr_valid),
    .dw_valid (dw_valid),
    .grant    (pick)
  );

  // Response payloads pass straight through; only the valids are steered.
  assign ir_data      = m_resp_data;
  assign dr_data      = m_resp_data;
  assign dw_resp      = m_resp;
  assign m_req_valid  = (state_q == arb_req);
  assign m_req_write  = m_req_write_q;
  assign m_req_addr   = m_req_addr_q;
  assign m_req_data   = m_req_data_q;
  assign m_req_strobe = m_req_strobe_q;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path
    // leaves one unassigned and no latch is inferred.
    state_d        = state_q;
    grant_d        = grant_q;
    m_req_write_d  = m_req_write_q;
    m_req_addr_d   = m_req_addr_q;
    m_req_data_d   = m_req_data_q;
    m_req_strobe_d = m_req_strobe_q;
    req_hs         = 1'b0;
    ir_addr_ready  = 1'b0;
    dr_addr_ready  = 1'b0;
    dw_ready       = 1'b0;
    ir_data_valid  = 1'b0;
    dr_data_valid  = 1'b0;
    dw_resp_valid  = 1'b0;
    m_resp_ready   = 1'b0;

    case (state_q)
      arb_idle: begin
        // The picker only grants a requester whose valid is high, so a
        // non-none pick is the request handshake.
        req_hs = (pick != grant_none);
        case (pick)
          grant_data_write: begin
            dw_ready       = 1'b1;
            m_req_write_d  = 1'b1;
            m_req_addr_d   = dw_addr;
            m_req_data_d   = dw_data;
            m_req_strobe_d = dw_strobe;
          end
          grant_data_read: begin
            dr_addr_ready  = 1'b1;
            m_req_write_d  = 1'b0;
            m_req_addr_d   = dr_addr;
            m_req_data_d   = '0;
            m_req_strobe_d = '0;
          end
          grant_inst: begin
            ir_addr_ready  = 1'b1;
            m_req_write_d  = 1'b0;
            m_req_addr_d   = ir_addr;
            m_req_data_d   = '0;
            m_req_strobe_d = '0;
          end
          default: ;
        endcase
        if (req_hs) begin
          grant_d = pick;
          state_d = arb_req;
        end
      end

      arb_req: begin
        if (m_req_ready) state_d = arb_resp;
      end

      arb_resp: begin
        case (grant_q)
          grant_data_write: begin
            dw_resp_valid = m_resp_valid;
            m_resp_ready  = dw_resp_ready;
          end
          grant_data_read: begin
            dr_data_valid = m_resp_valid;
            m_resp_ready  = dr_data_ready;
          end
          grant_inst: begin
            ir_data_valid = m_resp_valid;
            m_resp_ready  = ir_data_ready;
          end
          default: ;
        endcase
        if (m_resp_valid && m_resp_ready) begin
          state_d = arb_idle;
          grant_d = grant_none;
        end
      end

      default: state_d = arb_idle;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every register in the
  // design samples its pre-edge value regardless of process ordering.
  // NOTE: the payload registers are reset as well; they drive the shared port
  // directly and must read zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= arb_idle;
      grant_q        <= grant_none;
      m_req_write_q  <= 1'b0;
      m_req_addr_q   <= '0;
      m_req_data_q   <= '0;
      m_req_strobe_q <= '0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      m_req_write_q  <= m_req_write_d;
      m_req_addr_q   <= m_req_addr_d;
      m_req_data_q   <= m_req_data_d;
      m_req_strobe_q <= m_req_strobe_d;
    end
  end

endmodule

// File: tb/tb_copperv_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_copperv_mem_arbiter
// Scoreboard bench for copperv_mem_arbiter. Stimulus pushes the expected
// shared-port requests and per-requester responses into queues; a monitor
// pops and compares whenever the DUT shows a handshake. Inputs change 2 ns
// after the rising edge, outputs are sampled on the falling edge.
// Expected grant order depends on COPPERV_ARB_RR_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_copperv_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ir_addr_valid, ir_addr_ready, ir_data_valid, ir_data_ready;
  logic [31:0] ir_addr, ir_data;
  logic        dr_addr_valid, dr_addr_ready, dr_data_valid, dr_data_ready;
  logic [31:0] dr_addr, dr_data;
  logic        dw_valid, dw_ready, dw_resp_valid, dw_resp_ready;
  logic [31:0] dw_addr, dw_data;
  logic [3:0]  dw_strobe;
  logic [0:0]  dw_resp;
  logic        m_req_valid, m_req_ready, m_req_write;
  logic [31:0] m_req_addr, m_req_data;
  logic [3:0]  m_req_strobe;
  logic        m_resp_valid, m_resp_ready;
  logic [31:0] m_resp_data;
  logic [0:0]  m_resp;

  copperv_mem_arbiter #(.bus_width(32), .bus_resp_width(1), .strobe_width(4)) dut (
    .clk(clk), .rst(rst),
    .ir_addr_valid(ir_addr_valid), .ir_addr_ready(ir_addr_ready), .ir_addr(ir_addr),
    .ir_data_valid(ir_data_valid), .ir_data_ready(ir_data_ready), .ir_data(ir_data),
    .dr_addr_valid(dr_addr_valid), .dr_addr_ready(dr_addr_ready), .dr_addr(dr_addr),
    .dr_data_valid(dr_data_valid), .dr_data_ready(dr_data_ready), .dr_data(dr_data),
    .dw_valid(dw_valid), .dw_ready(dw_ready), .dw_addr(dw_addr), .dw_data(dw_data),
    .dw_strobe(dw_strobe), .dw_resp_valid(dw_resp_valid), .dw_resp_ready(dw_resp_ready),
    .dw_resp(dw_resp),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_write(m_req_write),
    .m_req_addr(m_req_addr), .m_req_data(m_req_data), .m_req_strobe(m_req_strobe),
    .m_resp_valid(m_resp_valid), .m_resp_ready(m_resp_ready),
    .m_resp_data(m_resp_data), .m_resp(m_resp)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strobe;
  } req_t;

  req_t        req_q[$];
  logic [31:0] ir_q[$];
  logic [31:0] dr_q[$];
  logic        dw_q[$];

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   n_req_hs = 0;
  int   n_ir_rdy = 0, n_dr_rdy = 0, n_dw_rdy = 0;
  int   last_ir_hs = 0;
  logic hold_req = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // Hand-written memory contents returned by the slave for reads.
  function automatic logic [31:0] slave_data(input logic [31:0] a);
    case (a)
      32'h100: return 32'hDEADBEEF;
      32'h104: return 32'h0BADF00D;
      32'h200: return 32'hCAFEF00D;
      32'h300: return 32'h12345678;
      default: return 32'h0;
    endcase
  endfunction

  // Slave: accepts unless hold_req, answers one cycle after acceptance and
  // holds the response until it is taken. Reset together with the DUT.
  initial begin
    logic        s_req_hs, s_resp_hs, s_wr, s_hold;
    logic [31:0] s_addr;
    m_req_ready  = 1'b1;
    m_resp_valid = 1'b0;
    m_resp_data  = '0;
    m_resp       = '0;
    forever begin
      @(negedge clk);
      s_req_hs  = m_req_valid && m_req_ready;
      s_resp_hs = m_resp_valid && m_resp_ready;
      s_wr      = m_req_write;
      s_addr    = m_req_addr;
      s_hold    = hold_req;
      @(posedge clk);
      #2;
      if (rst) begin
        m_resp_valid = 1'b0;
      end else begin
        if (s_resp_hs) m_resp_valid = 1'b0;
        if (s_req_hs) begin
          m_resp_valid = 1'b1;
          m_resp_data  = s_wr ? 32'h0 : slave_data(s_addr);
          m_resp       = s_wr;
        end
      end
      m_req_ready = !s_hold;
    end
  end

  // Monitor / scoreboard.
  initial begin
    req_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (ir_addr_valid && ir_addr_ready) n_ir_rdy++;
        if (dr_addr_valid && dr_addr_ready) n_dr_rdy++;
        if (dw_valid && dw_ready)           n_dw_rdy++;
        if (ir_addr_ready || dr_addr_ready || dw_ready)
          check("one_ready", 32'($countones({ir_addr_ready, dr_addr_ready, dw_ready})), 32'd1);
        if (ir_data_valid || dr_data_valid || dw_resp_valid)
          check("one_resp_valid", 32'($countones({ir_data_valid, dr_data_valid, dw_resp_valid})), 32'd1);
        if (m_req_valid && m_req_ready) begin
          n_req_hs++;
          if (req_q.size() == 0) fail_now("m_req unexpected request");
          else begin
            e = req_q.pop_front();
            check("m_req_write",  32'(m_req_write),  32'(e.write));
            check("m_req_addr",   m_req_addr,        e.addr);
            check("m_req_data",   m_req_data,        e.data);
            check("m_req_strobe", 32'(m_req_strobe), 32'(e.strobe));
          end
        end
        if (ir_data_valid && ir_data_ready) begin
          if (ir_q.size() == 0) fail_now("ir_data unexpected");
          else check("ir_data", ir_data, ir_q.pop_front());
        end
        if (dr_data_valid && dr_data_ready) begin
          if (dr_q.size() == 0) fail_now("dr_data unexpected");
          else check("dr_data", dr_data, dr_q.pop_front());
        end
        if (dw_resp_valid && dw_resp_ready) begin
          if (dw_q.size() == 0) fail_now("dw_resp unexpected");
          else check("dw_resp", 32'(dw_resp), 32'(dw_q.pop_front()));
        end
      end
    end
  end

  task automatic ir_req(input logic [31:0] a, input logic [31:0] exp);
    logic got = 1'b0;
    ir_q.push_back(exp);
    ir_addr = a;
    ir_addr_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ir_addr_ready) begin got = 1'b1; break; end
    end
    if (!got) fail_now("ir_addr_ready timeout");
    else last_ir_hs = cyc;
    tick();
    ir_addr_valid = 1'b0;
  endtask

  task automatic dr_req(input logic [31:0] a, input logic [31:0] exp);
    logic got = 1'b0;
    dr_q.push_back(exp);
    dr_addr = a;
    dr_addr_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (dr_addr_ready) begin got = 1'b1; break; end
    end
    if (!got) fail_now("dr_addr_ready timeout");
    tick();
    dr_addr_valid = 1'b0;
  endtask

  task automatic dw_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic exp);
    logic got = 1'b0;
    dw_q.push_back(exp);
    dw_addr = a;
    dw_data = d;
    dw_strobe = s;
    dw_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (dw_ready) begin got = 1'b1; break; end
    end
    if (!got) fail_now("dw_ready timeout");
    tick();
    dw_valid = 1'b0;
  endtask

  task automatic wait_ir_valid(input string name);
    logic got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ir_data_valid) begin got = 1'b1; break; end
    end
    if (!got) fail_now(name);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic drain;
    for (int i = 0; i < 100; i++) begin
      if (req_q.size() == 0 && ir_q.size() == 0 && dr_q.size() == 0 && dw_q.size() == 0) break;
      @(negedge clk);
    end
    check("queues_drained", 32'(req_q.size() + ir_q.size() + dr_q.size() + dw_q.size()), 32'd0);
    tick();
  endtask

  initial begin
    int   hs0, ir0, dr0, dw0;
    logic got;
    rst = 1'b1;
    ir_addr_valid = 0; ir_addr = '0; ir_data_ready = 1;
    dr_addr_valid = 0; dr_addr = '0; dr_data_ready = 1;
    dw_valid = 0; dw_addr = '0; dw_data = '0; dw_strobe = '0; dw_resp_ready = 1;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_m_req_valid",  32'(m_req_valid),  32'd0);
    check("rst_m_req_write",  32'(m_req_write),  32'd0);
    check("rst_m_req_addr",   m_req_addr,        32'd0);
    check("rst_m_req_data",   m_req_data,        32'd0);
    check("rst_m_req_strobe", 32'(m_req_strobe), 32'd0);
    check("rst_m_resp_ready", 32'(m_resp_ready), 32'd0);
    check("rst_readies", 32'({ir_addr_ready, dr_addr_ready, dw_ready}), 32'd0);
    check("rst_resp_valids", 32'({ir_data_valid, dr_data_valid, dw_resp_valid}), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Single instruction read: m_req_valid one cycle after, data two after.
    req_q.push_back('{write: 1'b0, addr: 32'h100, data: 32'h0, strobe: 4'h0});
    ir_req(32'h100, 32'hDEADBEEF);
    @(negedge clk);
    check("ir_m_req_valid_cycle1", 32'(m_req_valid), 32'd1);
    wait_ir_valid("ir_data_valid timeout");
    check("ir_latency", 32'(cyc - last_ir_hs), 32'd2);
    drain();

    // Single data write.
    req_q.push_back('{write: 1'b1, addr: 32'h20, data: 32'h1234, strobe: 4'b0011});
    dw_req(32'h20, 32'h1234, 4'b0011, 1'b1);
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (dw_resp_valid) begin got = 1'b1; break; end
    end
    if (!got) fail_now("dw_resp_valid timeout");
    check("dw_other_valids", 32'({ir_data_valid, dr_data_valid}), 32'd0);
    drain();

    // All three at once, one request each, from a fresh reset.
    do_reset();
    ir0 = n_ir_rdy; dr0 = n_dr_rdy; dw0 = n_dw_rdy;
    req_q.push_back('{write: 1'b1, addr: 32'h40,  data: 32'hA5A50001, strobe: 4'hF});
    req_q.push_back('{write: 1'b0, addr: 32'h200, data: 32'h0, strobe: 4'h0});
    req_q.push_back('{write: 1'b0, addr: 32'h104, data: 32'h0, strobe: 4'h0});
    fork
      dw_req(32'h40, 32'hA5A50001, 4'hF, 1'b1);
      dr_req(32'h200, 32'hCAFEF00D);
      ir_req(32'h104, 32'h0BADF00D);
    join
    drain();
    check("ir_ready_pulses", 32'(n_ir_rdy - ir0), 32'd1);
    check("dr_ready_pulses", 32'(n_dr_rdy - dr0), 32'd1);
    check("dw_ready_pulses", 32'(n_dw_rdy - dw0), 32'd1);

    // Continuous reissue, two requests per requester.
`ifdef COPPERV_ARB_RR_EN
    req_q.push_back('{write: 1'b1, addr: 32'h44,  data: 32'h1, strobe: 4'h1});
    req_q.push_back('{write: 1'b0, addr: 32'h200, data: 32'h0, strobe: 4'h0});
    req_q.push_back('{write: 1'b0, addr: 32'h100, data: 32'h0, strobe: 4'h0});
    req_q.push_back('{write: 1'b1, addr: 32'h48,  data: 32'h2, strobe: 4'h2});
    req_q.push_back('{write: 1'b0, addr: 32'h300, data: 32'h0, strobe: 4'h0});
    req_q.push_back('{write: 1'b0, addr: 32'h104, data: 32'h0, strobe: 4'h0});
`else
    req_q.push_back('{write: 1'b1, addr: 32'h44,  data: 32'h1, strobe: 4'h1});
    req_q.push_back('{write: 1'b1, addr: 32'h48,  data: 32'h2, strobe: 4'h2});
    req_q.push_back('{write: 1'b0, addr: 32'h200, data: 32'h0, strobe: 4'h0});
    req_q.push_back('{write: 1'b0, addr: 32'h300, data: 32'h0, strobe: 4'h0});
    req_q.push_back('{write: 1'b0, addr: 32'h100, data: 32'h0, strobe: 4'h0});
    req_q.push_back('{write: 1'b0, addr: 32'h104, data: 32'h0, strobe: 4'h0});
`endif
    fork
      begin dw_req(32'h44, 32'h1, 4'h1, 1'b1); dw_req(32'h48, 32'h2, 4'h2, 1'b1); end
      begin dr_req(32'h200, 32'hCAFEF00D); dr_req(32'h300, 32'h12345678); end
      begin ir_req(32'h100, 32'hDEADBEEF); ir_req(32'h104, 32'h0BADF00D); end
    join
    drain();

    // Back-pressure on both sides.
    hs0 = n_req_hs;
    hold_req = 1'b1;
    ir_data_ready = 1'b0;
    tick();
    req_q.push_back('{write: 1'b0, addr: 32'h300, data: 32'h0, strobe: 4'h0});
    ir_req(32'h300, 32'h12345678);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_m_req_valid",  32'(m_req_valid),  32'd1);
      check("bp_m_req_ready",  32'(m_req_ready),  32'd0);
      check("bp_m_req_addr",   m_req_addr,        32'h300);
      check("bp_m_resp_ready", 32'(m_resp_ready), 32'd0);
    end
    tick();
    hold_req = 1'b0;
    wait_ir_valid("bp ir_data_valid timeout");
    for (int i = 0; i < 3; i++) begin
      check("bp_ir_data_valid", 32'(ir_data_valid), 32'd1);
      check("bp_resp_held",     32'(m_resp_ready),  32'd0);
      check("bp_ir_data",       ir_data,            32'h12345678);
      @(negedge clk);
    end
    tick();
    ir_data_ready = 1'b1;
    drain();
    repeat (3) tick();
    check("bp_one_transaction", 32'(n_req_hs - hs0), 32'd1);

    // Reset while in the response phase.
    ir_data_ready = 1'b0;
    req_q.push_back('{write: 1'b0, addr: 32'h100, data: 32'h0, strobe: 4'h0});
    ir_req(32'h100, 32'hDEADBEEF);
    wait_ir_valid("rst ir_data_valid timeout");
    #1 rst = 1'b1;
    @(negedge clk);
    check("mid_rst_resp_valids", 32'({ir_data_valid, dr_data_valid, dw_resp_valid}), 32'd0);
    check("mid_rst_readies", 32'({ir_addr_ready, dr_addr_ready, dw_ready, m_resp_ready}), 32'd0);
    check("mid_rst_m_req_valid", 32'(m_req_valid), 32'd0);
    check("mid_rst_m_req_addr", m_req_addr, 32'd0);
    ir_q.delete();
    tick();
    ir_data_ready = 1'b1;
    rst = 1'b0;
    tick();
    req_q.push_back('{write: 1'b0, addr: 32'h200, data: 32'h0, strobe: 4'h0});
    dr_req(32'h200, 32'hCAFEF00D);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
